// File: rtl/fft_bfly_pair_stage_pkg.sv
// Shared constants and phase encoding for the paired radix-2 butterfly stage.
package fft_pkg;

  localparam int DEF_WIDTH      = 9;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_t;

endpackage

// File: rtl/fft_bfly_pair_stage_if.sv
// Vector bus between the upstream demux and the pair-butterfly stage.
interface fft_bfly_pair_stage_if
  import fft_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                    in_valid;
  logic                    clr;
  logic signed [WIDTH-1:0] reg_re  [0:DATA_WIDTH-1];
  logic signed [WIDTH-1:0] reg_im  [0:DATA_WIDTH-1];
  logic signed [WIDTH-1:0] cal_re  [0:DATA_WIDTH-1];
  logic signed [WIDTH-1:0] cal_im  [0:DATA_WIDTH-1];
  logic                    sel;
  logic                    out_valid;
  logic signed [WIDTH:0]   sum_re  [0:DATA_WIDTH-1];
  logic signed [WIDTH:0]   sum_im  [0:DATA_WIDTH-1];
  logic signed [WIDTH:0]   diff_re [0:DATA_WIDTH-1];
  logic signed [WIDTH:0]   diff_im [0:DATA_WIDTH-1];

  modport master (
    output in_valid, clr, reg_re, reg_im, cal_re, cal_im,
    input  sel, out_valid, sum_re, sum_im, diff_re, diff_im
  );

  modport slave (
    input  in_valid, clr, reg_re, reg_im, cal_re, cal_im,
    output sel, out_valid, sum_re, sum_im, diff_re, diff_im
  );

endinterface

// File: rtl/fft_bfly_pair_stage_bfly2.sv
// Single-lane combinational radix-2 butterfly; one guard bit keeps results exact.
module fft_bfly2
  import fft_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  output logic signed [WIDTH:0]   sum_re,
  output logic signed [WIDTH:0]   sum_im,
  output logic signed [WIDTH:0]   diff_re,
  output logic signed [WIDTH:0]   diff_im
);

  logic signed [WIDTH:0] a_re_x;
  logic signed [WIDTH:0] a_im_x;
  logic signed [WIDTH:0] b_re_x;
  logic signed [WIDTH:0] b_im_x;

  assign a_re_x = {a_re[WIDTH-1], a_re};
  assign a_im_x = {a_im[WIDTH-1], a_im};
  assign b_re_x = {b_re[WIDTH-1], b_re};
  assign b_im_x = {b_im[WIDTH-1], b_im};

  assign sum_re  = a_re_x + b_re_x;
  assign sum_im  = a_im_x + b_im_x;
  assign diff_re = a_re_x - b_re_x;
  assign diff_im = a_im_x - b_im_x;

endmodule

// File: rtl/fft_bfly_pair_stage.sv
// Two-phase pair collector feeding DATA_WIDTH butterflies with registered results.
// Optional FFT_PAIR_CNT_EN adds a 16-bit completed-pair counter output.
module fft_bfly_pair_stage
  import fft_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef FFT_PAIR_CNT_EN
  output logic [15:0]           pair_cnt,
`endif
  fft_bfly_pair_stage_if.slave  bus
);

  phase_t phase_reg;
  phase_t phase_next;
  logic   capture;
  logic   compute;
  logic   out_valid_reg;

  // clr outranks in_valid so a flushed cycle neither captures nor computes
  always_comb begin
    phase_next = phase_reg;
    capture    = 1'b0;
    compute    = 1'b0;
    if (bus.clr) begin
      phase_next = PH_A;
    end else if (bus.in_valid) begin
      case (phase_reg)
        PH_A: begin
          capture    = 1'b1;
          phase_next = PH_B;
        end
        PH_B: begin
          compute    = 1'b1;
          phase_next = PH_A;
        end
        default: phase_next = PH_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg     <= PH_A;
      out_valid_reg <= 1'b0;
    end else begin
      phase_reg     <= phase_next;
      out_valid_reg <= compute;
    end
  end

  assign bus.sel       = (phase_reg == PH_B);
  assign bus.out_valid = out_valid_reg;

`ifdef FFT_PAIR_CNT_EN
  logic [15:0] pair_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt_reg <= '0;
    end else if (bus.clr) begin
      pair_cnt_reg <= '0;
    end else if (compute) begin
      pair_cnt_reg <= pair_cnt_reg + 16'd1;
    end
  end

  assign pair_cnt = pair_cnt_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_lane
      logic signed [WIDTH-1:0] hold_re_reg;
      logic signed [WIDTH-1:0] hold_im_reg;
      logic signed [WIDTH:0]   sum_re_next;
      logic signed [WIDTH:0]   sum_im_next;
      logic signed [WIDTH:0]   diff_re_next;
      logic signed [WIDTH:0]   diff_im_next;
      logic signed [WIDTH:0]   sum_re_reg;
      logic signed [WIDTH:0]   sum_im_reg;
      logic signed [WIDTH:0]   diff_re_reg;
      logic signed [WIDTH:0]   diff_im_reg;

      fft_bfly2 #(
        .WIDTH (WIDTH)
      ) u_bfly (
        .a_re    (hold_re_reg),
        .a_im    (hold_im_reg),
        .b_re    (bus.cal_re[gi]),
        .b_im    (bus.cal_im[gi]),
        .sum_re  (sum_re_next),
        .sum_im  (sum_im_next),
        .diff_re (diff_re_next),
        .diff_im (diff_im_next)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_re_reg <= '0;
          hold_im_reg <= '0;
          sum_re_reg  <= '0;
          sum_im_reg  <= '0;
          diff_re_reg <= '0;
          diff_im_reg <= '0;
        end else begin
          if (capture) begin
            hold_re_reg <= bus.reg_re[gi];
            hold_im_reg <= bus.reg_im[gi];
          end
          if (compute) begin
            sum_re_reg  <= sum_re_next;
            sum_im_reg  <= sum_im_next;
            diff_re_reg <= diff_re_next;
            diff_im_reg <= diff_im_next;
          end
        end
      end

      assign bus.sum_re[gi]  = sum_re_reg;
      assign bus.sum_im[gi]  = sum_im_reg;
      assign bus.diff_re[gi] = diff_re_reg;
      assign bus.diff_im[gi] = diff_im_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fft_bfly_pair_stage.sv
// Directed table-driven bench for fft_bfly_pair_stage plus clr/reset/gap sequences.
module tb_fft_bfly_pair_stage;

  localparam int W = 9;
  localparam int D = 16;

  typedef struct {
    logic signed [W-1:0] r_re;
    logic signed [W-1:0] r_im;
    logic signed [W-1:0] c_re;
    logic signed [W-1:0] c_im;
    logic signed [W:0]   s_re;
    logic signed [W:0]   s_im;
    logic signed [W:0]   d_re;
    logic signed [W:0]   d_im;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [15:0] exp_cnt;
  vec_t tv [6];

  fft_bfly_pair_stage_if #(.WIDTH(W), .DATA_WIDTH(D)) bus ();

`ifdef FFT_PAIR_CNT_EN
  logic [15:0] pair_cnt;
`endif

  fft_bfly_pair_stage #(
    .WIDTH      (W),
    .DATA_WIDTH (D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef FFT_PAIR_CNT_EN
    .pair_cnt (pair_cnt),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
`ifdef FFT_PAIR_CNT_EN
    chk({name, ".pair_cnt"}, int'(pair_cnt), int'(exp_cnt));
`endif
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    for (int i = 0; i < D; i++) begin
      bus.reg_re[i] = '0;
      bus.reg_im[i] = '0;
      bus.cal_re[i] = '0;
      bus.cal_im[i] = '0;
    end
  endtask

  task automatic drive_reg(input vec_t v);
    bus.in_valid = 1'b1;
    for (int i = 0; i < D; i++) begin
      bus.reg_re[i] = v.r_re;
      bus.reg_im[i] = v.r_im;
      bus.cal_re[i] = '0;
      bus.cal_im[i] = '0;
    end
  endtask

  task automatic drive_cal(input vec_t v);
    bus.in_valid = 1'b1;
    for (int i = 0; i < D; i++) begin
      bus.reg_re[i] = '0;
      bus.reg_im[i] = '0;
      bus.cal_re[i] = v.c_re;
      bus.cal_im[i] = v.c_im;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lanes(input vec_t v, input string tag);
    for (int i = 0; i < D; i++) begin
      chk($sformatf("%s.sum_re[%0d]", tag, i),  int'(bus.sum_re[i]),  int'(v.s_re));
      chk($sformatf("%s.sum_im[%0d]", tag, i),  int'(bus.sum_im[i]),  int'(v.s_im));
      chk($sformatf("%s.diff_re[%0d]", tag, i), int'(bus.diff_re[i]), int'(v.d_re));
      chk($sformatf("%s.diff_im[%0d]", tag, i), int'(bus.diff_im[i]), int'(v.d_im));
    end
  endtask

  task automatic run_pair(input vec_t v, input int gap, input string tag);
    int f0;
    f0 = fails;
    chk({tag, ".sel_a"}, int'(bus.sel), 0);
    drive_reg(v);
    tick();
    chk({tag, ".sel_b"}, int'(bus.sel), 1);
    chk({tag, ".ov_after_a"}, int'(bus.out_valid), 0);
    drive_idle();
    for (int g = 0; g < gap; g++) begin
      tick();
      chk($sformatf("%s.gap%0d.ov", tag, g), int'(bus.out_valid), 0);
      chk($sformatf("%s.gap%0d.sel", tag, g), int'(bus.sel), 1);
    end
    drive_cal(v);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, ".ov_pulse"}, int'(bus.out_valid), 1);
    chk({tag, ".sel_back"}, int'(bus.sel), 0);
    check_lanes(v, tag);
    chk_cnt(tag);
    drive_idle();
    tick();
    chk({tag, ".ov_drop"}, int'(bus.out_valid), 0);
    check_lanes(v, {tag, ".hold"});
    $display("[TB] pair %s reg=%0d/%0d cal=%0d/%0d sum=%0d/%0d diff=%0d/%0d errors=%0d",
             tag, v.r_re, v.r_im, v.c_re, v.c_im, bus.sum_re[0], bus.sum_im[0],
             bus.diff_re[0], bus.diff_im[0], fails - f0);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    exp_cnt = '0;

    tv[0] = '{9'sd3,    -9'sd2,   9'sd5,    9'sd1,    10'sd8,    -10'sd1,  -10'sd2,   -10'sd3};
    tv[1] = '{9'sd255,  9'sd255,  9'sd255,  9'sd255,  10'sd510,  10'sd510, 10'sd0,    10'sd0};
    tv[2] = '{-9'sd256, -9'sd256, 9'sd255,  9'sd255,  -10'sd1,   -10'sd1,  -10'sd511, -10'sd511};
    tv[3] = '{-9'sd256, 9'sd255,  -9'sd256, -9'sd256, -10'sd512, -10'sd1,  10'sd0,    10'sd511};
    tv[4] = '{9'sd100,  -9'sd7,   -9'sd50,  9'sd20,   10'sd50,   10'sd13,  10'sd150,  -10'sd27};
    tv[5] = '{9'sd0,    9'sd0,    9'sd0,    9'sd0,    10'sd0,    10'sd0,   10'sd0,    10'sd0};

    rst_n   = 1'b0;
    bus.clr = 1'b0;
    drive_idle();
    tick();
    tick();
    chk("reset.sel", int'(bus.sel), 0);
    chk("reset.out_valid", int'(bus.out_valid), 0);
    chk("reset.sum_re0", int'(bus.sum_re[0]), 0);
    chk("reset.diff_im15", int'(bus.diff_im[D-1]), 0);
    chk_cnt("reset");
    rst_n = 1'b1;
    tick();
    chk("idle.out_valid", int'(bus.out_valid), 0);
    chk("idle.sel", int'(bus.sel), 0);

    for (int k = 0; k < 6; k++) begin
      run_pair(tv[k], 0, $sformatf("vec%0d", k));
    end

    run_pair(tv[4], 3, "gap3");

    // clr in PH_A with valid data: nothing captured
    bus.clr = 1'b1;
    drive_reg(tv[1]);
    tick();
    exp_cnt = '0;
    chk("clr_a.sel", int'(bus.sel), 0);
    chk("clr_a.out_valid", int'(bus.out_valid), 0);
    chk_cnt("clr_a");
    bus.clr = 1'b0;
    drive_idle();
    tick();

    // clr in PH_B together with the second vector: pair aborted
    drive_reg(tv[1]);
    tick();
    chk("clr_b.sel_before", int'(bus.sel), 1);
    drive_cal(tv[1]);
    bus.clr = 1'b1;
    tick();
    chk("clr_b.out_valid", int'(bus.out_valid), 0);
    chk("clr_b.sel", int'(bus.sel), 0);
    chk("clr_b.sum_re_held", int'(bus.sum_re[0]), int'(tv[4].s_re));
    chk_cnt("clr_b");
    bus.clr = 1'b0;
    drive_idle();
    tick();
    chk("clr_b.no_pulse", int'(bus.out_valid), 0);
    run_pair(tv[0], 0, "after_clr");

    // asynchronous reset mid-pair
    drive_reg(tv[4]);
    tick();
    chk("rst_mid.sel_before", int'(bus.sel), 1);
    drive_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_mid.sel", int'(bus.sel), 0);
    chk("rst_mid.out_valid", int'(bus.out_valid), 0);
    chk("rst_mid.sum_re0", int'(bus.sum_re[0]), 0);
    chk("rst_mid.diff_re0", int'(bus.diff_re[0]), 0);
    chk("rst_mid.sum_im7", int'(bus.sum_im[7]), 0);
    exp_cnt = '0;
    chk_cnt("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_post.out_valid", int'(bus.out_valid), 0);
    chk("rst_post.sel", int'(bus.sel), 0);
    tick();
    chk("rst_post2.out_valid", int'(bus.out_valid), 0);
    run_pair(tv[2], 0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
